// File: rtl/soc_defs.sv
// Shared constants, types and state encoding for the instruction cache.
// Geometry: 64 single-word lines, 6-bit index, 24-bit tag.
package soc_defs;

  localparam int ICACHE_LINES   = 64;
  localparam int ICACHE_INDEX_W = 6;
  localparam int ICACHE_TAG_W   = 24;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_e;

  typedef logic [ICACHE_INDEX_W-1:0] icache_idx_t;
  typedef logic [ICACHE_TAG_W-1:0]   icache_tag_t;

  function automatic icache_idx_t addr_idx(input logic [31:0] a);
    return a[ICACHE_INDEX_W+1:2];
  endfunction

  function automatic icache_tag_t addr_tag(input logic [31:0] a);
    return a[31:ICACHE_INDEX_W+2];
  endfunction

endpackage

// File: rtl/inst_cache_ram.sv
// Line storage: data, tag and valid arrays with async read, sync write and flush-all.
// Ports: clk, rst (async active-low), flush, we/widx/wtag/wdata, ridx -> rvalid/rtag/rdata.
import soc_defs::*;

module inst_cache_ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        we,
  input  icache_idx_t widx,
  input  icache_tag_t wtag,
  input  logic [31:0] wdata,
  input  icache_idx_t ridx,
  output logic        rvalid,
  output icache_tag_t rtag,
  output logic [31:0] rdata
);

  logic [ICACHE_LINES-1:0] valid_q;
  icache_tag_t             tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache, 64 x 1-word lines, blocking single-word fill.
// Ports: clk, rst, core fetch (inst_addr_i/inst_data_o/inst_valid_o), flush_i,
// fill bus (mem_addr_o/mem_rd_o/mem_data_i/mem_valid_i); ICACHE_STATS_EN adds
// hit_count_o/miss_count_o.
import soc_defs::*;

module inst_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_valid_o,
  input  logic        flush_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  icache_state_e state_q, state_d;
  logic [31:0]   req_addr_q;
  logic          kill_q;
  logic          start;
  logic          fill_we;
  logic          hit;
  logic          line_valid;
  icache_tag_t   line_tag;
  logic [31:0]   line_data;
  logic [1:0]    unused_bits;

  assign unused_bits = inst_addr_i[1:0];

  inst_cache_ram u_ram (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush_i),
    .we     (fill_we),
    .widx   (addr_idx(req_addr_q)),
    .wtag   (addr_tag(req_addr_q)),
    .wdata  (mem_data_i),
    .ridx   (addr_idx(inst_addr_i)),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  // Flush masks the lookup so a line about to be invalidated is never used.
  assign hit = (state_q == IDLE) && !flush_i && line_valid
             && (line_tag == addr_tag(inst_addr_i));

  assign inst_valid_o = hit;
  assign inst_data_o  = hit ? line_data : 32'h0;
  assign mem_rd_o     = (state_q == FILL);
  assign mem_addr_o   = (state_q == FILL) ? req_addr_q : 32'h0;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fill_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && !hit) begin
          state_d = FILL;
          start   = 1'b1;
        end
      end
      FILL: begin
        if (mem_valid_i) begin
          state_d = IDLE;
          fill_we = !kill_q && !flush_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        req_addr_q <= {inst_addr_i[31:2], 2'b00};
      end
    end
  end

  // A flush seen at any point of a fill poisons that fill's write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_q <= 1'b0;
    end else if (state_q == FILL) begin
      if (mem_valid_i) begin
        kill_q <= 1'b0;
      end else if (flush_i) begin
        kill_q <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_o  <= 32'h0;
      miss_count_o <= 32'h0;
    end else begin
      if (hit) begin
        hit_count_o <= hit_count_o + 32'd1;
      end
      if (start) begin
        miss_count_o <= miss_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomised + directed bench for inst_cache against a line-address model.
// Optional stats ports are checked when ICACHE_STATS_EN is defined.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        inst_valid_o;
  logic        flush_i;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;
`endif

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr_i  (inst_addr_i),
    .inst_data_o  (inst_data_o),
    .inst_valid_o (inst_valid_o),
    .flush_i      (flush_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_data_i   (mem_data_i),
    .mem_valid_i  (mem_valid_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // Model: which word address each of the 64 slots holds, plus backing memory.
  bit          m_vld [64];
  logic [31:0] m_adr [64];
  logic [31:0] memv [logic [31:0]];
  int          m_hits;
  int          m_miss;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] w);
    return int'((w / 4) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] w);
    return m_vld[slot(w)] && (m_adr[slot(w)] == w);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] w);
    if (!memv.exists(w)) memv[w] = $urandom;
    return memv[w];
  endfunction

  task automatic m_flush();
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic fetch(input logic [31:0] a, input int dly, input int kmode,
                       input bit chg, input logic [31:0] alt);
    logic [31:0] w;
    logic [31:0] d;
    bit          h;
    w = {a[31:2], 2'b00};
    if (kmode == 2 && dly < 1) dly = 1;
    inst_addr_i = a;
    h = m_hit(w);
    @(negedge clk);
    chk("hit", {31'b0, inst_valid_o}, {31'b0, h});
    chk("data", inst_data_o, h ? m_word(w) : 32'h0);
    chk("idle_rd", {31'b0, mem_rd_o}, 32'h0);
    chk("idle_addr", mem_addr_o, 32'h0);
    @(posedge clk); #1;
    if (h) begin
      m_hits++;
      return;
    end
    m_miss++;
    for (int i = 0; i < dly; i++) begin
      inst_addr_i = chg ? alt : a;
      flush_i = (kmode == 2 && i == 0);
      @(negedge clk);
      chk("fill_rd", {31'b0, mem_rd_o}, 32'h1);
      chk("fill_addr", mem_addr_o, w);
      chk("fill_vld", {31'b0, inst_valid_o}, 32'h0);
      chk("fill_data", inst_data_o, 32'h0);
      @(posedge clk); #1;
      if (flush_i) m_flush();
      flush_i = 1'b0;
    end
    inst_addr_i = chg ? alt : a;
    d = m_word(w);
    mem_valid_i = 1'b1;
    mem_data_i = d;
    flush_i = (kmode == 1);
    @(negedge clk);
    chk("done_rd", {31'b0, mem_rd_o}, 32'h1);
    chk("done_addr", mem_addr_o, w);
    chk("done_vld", {31'b0, inst_valid_o}, 32'h0);
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    mem_data_i = $urandom;
    flush_i = 1'b0;
    if (kmode != 0) begin
      m_flush();
    end else begin
      m_vld[slot(w)] = 1'b1;
      m_adr[slot(w)] = w;
    end
  endtask

  task automatic flush_idle(input logic [31:0] a);
    inst_addr_i = a;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_vld", {31'b0, inst_valid_o}, 32'h0);
    chk("flush_data", inst_data_o, 32'h0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    m_flush();
    chk("flush_nofill", {31'b0, mem_rd_o}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_vld", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_data", inst_data_o, 32'h0);
    chk("rst_rd", {31'b0, mem_rd_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    rst = 1'b1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    m_flush();
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count_o, m_hits);
    chk("miss_count", miss_count_o, m_miss);
`endif
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst = 1'b0;
    inst_addr_i = 32'h0;
    flush_i = 1'b0;
    mem_data_i = 32'h0;
    mem_valid_i = 1'b0;
    m_flush();
    @(posedge clk); #1;
    do_reset();

    memv[32'h0] = 32'h3C010001;
    fetch(32'h000, 0, 0, 0, 0);
    fetch(32'h000, 0, 0, 0, 0);

    fetch(32'h004, 1, 0, 0, 0);
    fetch(32'h004, 0, 0, 0, 0);
    fetch(32'h104, 0, 0, 0, 0);
    fetch(32'h004, 0, 0, 0, 0);

    fetch(32'h010, 0, 1, 0, 0);
    fetch(32'h010, 0, 0, 0, 0);
    fetch(32'h014, 2, 2, 0, 0);
    fetch(32'h014, 0, 0, 0, 0);

    fetch(32'h020, 0, 0, 0, 0);
    fetch(32'h024, 0, 0, 0, 0);
    fetch(32'h028, 0, 0, 0, 0);
    flush_idle(32'h020);
    fetch(32'h020, 0, 0, 0, 0);
    fetch(32'h024, 0, 0, 0, 0);
    fetch(32'h028, 0, 0, 0, 0);

    fetch(32'h008, 2, 0, 1, 32'h00C);
    fetch(32'h008, 0, 0, 0, 0);
    fetch(32'h00C, 0, 0, 0, 0);
    chk_stats();

    // Reset in the middle of a fill; the late data must be dropped.
    inst_addr_i = 32'h030;
    @(posedge clk); #1;
    chk("pre_rst_rd", {31'b0, mem_rd_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_fill_rd", {31'b0, mem_rd_o}, 32'h0);
    chk("rst_fill_addr", mem_addr_o, 32'h0);
    rst = 1'b1;
    flush_i = 1'b1;
    mem_valid_i = 1'b1;
    mem_data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    flush_i = 1'b0;
    mem_valid_i = 1'b0;
    m_flush();
    m_hits = 0;
    m_miss = 0;
    chk("rst_late_rd", {31'b0, mem_rd_o}, 32'h0);
    fetch(32'h030, 0, 0, 0, 0);

    do_reset();
    fetch(32'h040, 0, 0, 0, 0);
    fetch(32'h044, 1, 0, 0, 0);
    fetch(32'h040, 0, 0, 0, 0);
    fetch(32'h040, 0, 0, 0, 0);
    fetch(32'h040, 0, 0, 0, 0);
    fetch(32'h044, 0, 0, 0, 0);
    fetch(32'h044, 0, 0, 0, 0);
    chk_stats();

    for (int it = 0; it < 300; it++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)
        | $urandom_range(0, 3);
      op = $urandom_range(0, 19);
      if (op == 0) begin
        flush_idle(a);
      end else if (op == 1) begin
        fetch(a, $urandom_range(0, 3), $urandom_range(1, 2), 0, 0);
      end else begin
        fetch(a, $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0),
              $urandom);
      end
    end
    chk_stats();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
